lmsm_sequencer: RTL and testbench

LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

---
 rtl/lmsm_sequencer.sv | 175 +++++++++++++++++
 tb/tb_lmsm_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmsm_sequencer.sv
// ============================================================================
// Module   : lmsm_sequencer
// Function : Load/store-multiple sequencer walking an 8-bit register list.
//            Optional macro LMSM_WRAP_ERR_EN turns address wrap into an error.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lmsm_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_is_store,
    input  logic [7:0]  i_reg_list,
    input  logic [15:0] i_base_addr,
    output logic [2:0]  o_rf_rd_addr,
    input  logic [15:0] i_rf_rd_data,
    output logic [2:0]  o_rf_wr_addr,
    output logic [15:0] o_rf_wr_data,
    output logic        o_rf_wr_en,
    output logic        o_pc_wr_en,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wr_data,
    output logic        o_mem_rd_en,
    output logic        o_mem_wr_en,
    input  logic        i_mem_ready,
    input  logic [15:0] i_mem_rd_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_list;
    logic [7:0]  w_list_nxt;
    logic [15:0] r_addr;
    logic [15:0] w_addr_nxt;
    logic        r_is_store;
    logic        w_is_store_nxt;
    logic [2:0]  w_idx;
    logic [7:0]  w_list_clr;
`ifdef LMSM_WRAP_ERR_EN
    logic        r_err;
    logic        w_err_nxt;
`endif

    // Lowest set bit wins: scan high to low so the last hit is the lowest.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (r_list[i]) begin
                w_idx = i[2:0];
            end
        end
    end

    assign w_list_clr = r_list & ~(8'd1 << w_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_list     <= 8'd0;
            r_addr     <= 16'd0;
            r_is_store <= 1'b0;
`ifdef LMSM_WRAP_ERR_EN
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_list     <= w_list_nxt;
            r_addr     <= w_addr_nxt;
            r_is_store <= w_is_store_nxt;
`ifdef LMSM_WRAP_ERR_EN
            r_err      <= w_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_list_nxt     = r_list;
        w_addr_nxt     = r_addr;
        w_is_store_nxt = r_is_store;
`ifdef LMSM_WRAP_ERR_EN
        w_err_nxt      = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_list_nxt     = i_reg_list;
                    w_addr_nxt     = i_base_addr;
                    w_is_store_nxt = i_is_store;
`ifdef LMSM_WRAP_ERR_EN
                    w_err_nxt      = 1'b0;
`endif
                    w_state_nxt    = (|i_reg_list) ? S_XFER : S_DONE;
                end
            end
            S_XFER: begin
                if (i_mem_ready) begin
                    w_list_nxt = w_list_clr;
                    w_addr_nxt = r_addr + 16'd1;
                    if (w_list_clr == 8'd0) begin
                        w_state_nxt = S_DONE;
                    end
`ifdef LMSM_WRAP_ERR_EN
                    // Leftover registers past 0xFFFF are abandoned, not wrapped.
                    else if (r_addr == 16'hFFFF) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = 1'b1;
                    end
`endif
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_rf_rd_addr  = 3'd0;
        o_rf_wr_addr  = 3'd0;
        o_rf_wr_data  = 16'd0;
        o_rf_wr_en    = 1'b0;
        o_pc_wr_en    = 1'b0;
        o_mem_addr    = 16'd0;
        o_mem_wr_data = 16'd0;
        o_mem_rd_en   = 1'b0;
        o_mem_wr_en   = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        o_err         = 1'b0;
        case (r_state)
            S_XFER: begin
                o_busy     = 1'b1;
                o_mem_addr = r_addr;
                if (r_is_store) begin
                    o_rf_rd_addr  = w_idx;
                    o_mem_wr_data = i_rf_rd_data;
                    o_mem_wr_en   = 1'b1;
                end else begin
                    o_mem_rd_en  = 1'b1;
                    o_rf_wr_addr = w_idx;
                    o_rf_wr_data = i_mem_rd_data;
                    // R7 is the PC and goes through its own write port.
                    o_rf_wr_en   = i_mem_ready && (w_idx != 3'd7);
                    o_pc_wr_en   = i_mem_ready && (w_idx == 3'd7);
                end
            end
            S_DONE: begin
                o_done = 1'b1;
`ifdef LMSM_WRAP_ERR_EN
                o_err  = r_err;
`endif
            end
            default: begin
                o_done = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_lmsm_sequencer.sv
// ============================================================================
// Module   : tb_lmsm_sequencer
// Function : Scoreboard bench for lmsm_sequencer with directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lmsm_sequencer;

    localparam logic [2:0] K_ST   = 3'd0;
    localparam logic [2:0] K_LDRF = 3'd1;
    localparam logic [2:0] K_LDPC = 3'd2;
    localparam logic [2:0] K_DONE = 3'd3;
    localparam logic [2:0] K_BAD  = 3'd6;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] maddr;
        logic [2:0]  ridx;
        logic [15:0] data;
        logic        err;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [7:0]  reg_list;
    logic [15:0] base_addr;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic [2:0]  rf_wr_addr;
    logic [15:0] rf_wr_data;
    logic        rf_wr_en;
    logic        pc_wr_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_wr_data;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic        mem_ready;
    logic [15:0] mem_rd_data;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;
    ev_t exp_q[$];

    lmsm_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_is_store   (is_store),
        .i_reg_list   (reg_list),
        .i_base_addr  (base_addr),
        .o_rf_rd_addr (rf_rd_addr),
        .i_rf_rd_data (rf_rd_data),
        .o_rf_wr_addr (rf_wr_addr),
        .o_rf_wr_data (rf_wr_data),
        .o_rf_wr_en   (rf_wr_en),
        .o_pc_wr_en   (pc_wr_en),
        .o_mem_addr   (mem_addr),
        .o_mem_wr_data(mem_wr_data),
        .o_mem_rd_en  (mem_rd_en),
        .o_mem_wr_en  (mem_wr_en),
        .i_mem_ready  (mem_ready),
        .i_mem_rd_data(mem_rd_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] memdata(input logic [15:0] a);
        if (a == 16'h0100)      return 16'hAAAA;
        else if (a == 16'h0101) return 16'h5555;
        else                    return a ^ 16'h3C00;
    endfunction

    assign rf_rd_data  = 16'hC000 | {13'd0, rf_rd_addr};
    assign mem_rd_data = memdata(mem_addr);

    wire [60:0] all_outs = {rf_rd_addr, rf_wr_addr, rf_wr_data, rf_wr_en, pc_wr_en,
                            mem_addr, mem_wr_data, mem_rd_en, mem_wr_en, busy, done, err};

    task automatic push(input logic [2:0] k, input logic [15:0] a, input logic [2:0] r,
                        input logic [15:0] d, input logic e);
        ev_t ev;
        ev.kind = k; ev.maddr = a; ev.ridx = r; ev.data = d; ev.err = e;
        exp_q.push_back(ev);
    endtask

    task automatic check_ev(input ev_t obs);
        ev_t ex;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got kind=%0d addr=%h idx=%0d data=%h err=%b, expected nothing",
                     obs.kind, obs.maddr, obs.ridx, obs.data, obs.err);
        end else begin
            ex = exp_q.pop_front();
            if (obs !== ex) begin
                n_fail++;
                $display("FAIL event: got kind=%0d addr=%h idx=%0d data=%h err=%b, expected kind=%0d addr=%h idx=%0d data=%h err=%b",
                         obs.kind, obs.maddr, obs.ridx, obs.data, obs.err,
                         ex.kind, ex.maddr, ex.ridx, ex.data, ex.err);
            end
        end
    endtask

    // Monitor: every completed transfer and every done pulse is one event.
    always @(negedge clk) begin
        ev_t obs;
        if (rst_n) begin
            if ((mem_wr_en || mem_rd_en) && mem_ready) begin
                obs.maddr = mem_addr;
                obs.err   = err;
                if (mem_wr_en && !mem_rd_en && !rf_wr_en && !pc_wr_en) begin
                    obs.kind = K_ST;
                    obs.ridx = rf_rd_addr;
                    obs.data = mem_wr_data;
                end else begin
                    if (rf_wr_en && !pc_wr_en && !mem_wr_en)      obs.kind = K_LDRF;
                    else if (pc_wr_en && !rf_wr_en && !mem_wr_en) obs.kind = K_LDPC;
                    else                                          obs.kind = K_BAD;
                    obs.ridx = rf_wr_addr;
                    obs.data = rf_wr_data;
                end
                check_ev(obs);
            end
            if (done) begin
                obs.kind = K_DONE; obs.maddr = 16'd0; obs.ridx = 3'd0;
                obs.data = 16'd0;  obs.err = err;
                check_ev(obs);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic issue(input logic st, input logic [7:0] lst, input logic [15:0] base);
        is_store  = st;
        reg_list  = lst;
        base_addr = base;
        start     = 1'b1;
        step();
        start     = 1'b0;
        reg_list  = 8'hA5;
        base_addr = 16'h7777;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 64) begin
            step();
            cyc++;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: done not seen after %0d cycles, expected within 64", cyc);
        end
        step();
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; reg_list = 8'd0;
        base_addr = 16'd0; mem_ready = 1'b1;
        step(); step();
        check("reset_outputs", {3'd0, all_outs}, 64'd0);
        rst_n = 1'b1;
        step();

        // Store R0,R2 from 0x0040
        push(K_ST, 16'h0040, 3'd0, 16'hC000, 1'b0);
        push(K_ST, 16'h0041, 3'd2, 16'hC002, 1'b0);
        push(K_DONE, 16'd0, 3'd0, 16'd0, 1'b0);
        issue(1'b1, 8'b0000_0101, 16'h0040);
        check("busy_in_xfer", {63'd0, busy}, 64'd1);
        wait_done(cyc);
        check("store_latency", 64'(cyc), 64'd2);

        // Load R1 and PC from 0x0100
        push(K_LDRF, 16'h0100, 3'd1, 16'hAAAA, 1'b0);
        push(K_LDPC, 16'h0101, 3'd7, 16'h5555, 1'b0);
        push(K_DONE, 16'd0, 3'd0, 16'd0, 1'b0);
        issue(1'b0, 8'b1000_0010, 16'h0100);
        wait_done(cyc);

        // Empty list: straight to DONE
        push(K_DONE, 16'd0, 3'd0, 16'd0, 1'b0);
        issue(1'b0, 8'h00, 16'h1234);
        check("empty_done_now", {63'd0, done}, 64'd1);
        check("empty_no_busy", {60'd0, busy, mem_rd_en, mem_wr_en, rf_wr_en}, 64'd0);
        wait_done(cyc);
        check("empty_latency", 64'(cyc), 64'd0);

        // Load all eight with a 2-cycle stall on the third transfer
        for (int k = 0; k < 7; k++)
            push(K_LDRF, 16'h0200 + 16'(k), 3'(k), 16'h3E00 + 16'(k), 1'b0);
        push(K_LDPC, 16'h0207, 3'd7, 16'h3E07, 1'b0);
        push(K_DONE, 16'd0, 3'd0, 16'd0, 1'b0);
        issue(1'b0, 8'hFF, 16'h0200);
        step(); step();
        mem_ready = 1'b0;
        #1;
        check("stall1_addr_nowr", {45'd0, mem_addr, rf_wr_en, pc_wr_en, mem_rd_en},
              {45'd0, 16'h0202, 1'b0, 1'b0, 1'b1});
        step();
        check("stall2_addr_nowr", {45'd0, mem_addr, rf_wr_en, pc_wr_en, mem_rd_en},
              {45'd0, 16'h0202, 1'b0, 1'b0, 1'b1});
        step();
        mem_ready = 1'b1;
        wait_done(cyc);
        check("stall_remaining_cycles", 64'(cyc), 64'd6);

        // Address wrap at 0xFFFF
        push(K_ST, 16'hFFFF, 3'd0, 16'hC000, 1'b0);
`ifdef LMSM_WRAP_ERR_EN
        push(K_DONE, 16'd0, 3'd0, 16'd0, 1'b1);
`else
        push(K_ST, 16'h0000, 3'd1, 16'hC001, 1'b0);
        push(K_DONE, 16'd0, 3'd0, 16'd0, 1'b0);
`endif
        issue(1'b1, 8'b0000_0011, 16'hFFFF);
        wait_done(cyc);

        // Reset during the second transfer of a 4-register store
        push(K_ST, 16'h0300, 3'd0, 16'hC000, 1'b0);
        issue(1'b1, 8'h0F, 16'h0300);
        step();
        rst_n = 1'b0;
        #1;
        check("abort_outputs_zero", {3'd0, all_outs}, 64'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        check("idle_after_release", {3'd0, all_outs}, 64'd0);
        step();

        push(K_LDRF, 16'h0010, 3'd0, 16'h3C10, 1'b0);
        push(K_DONE, 16'd0, 3'd0, 16'd0, 1'b0);
        issue(1'b0, 8'h01, 16'h0010);
        wait_done(cyc);
        check("fresh_latency", 64'(cyc), 64'd1);

        step(); step();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
